// File: rtl/cpu_bus_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto a single line-wide memory bus.
// One transaction at a time, with a watchdog that forces a retry when memory stays silent.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_stb,
  input  logic         i_we,
  input  logic [11:0]  i_adr,
  input  logic [127:0] i_dat_m,
  input  logic [15:0]  i_sel,
  output logic [127:0] i_dat_s,
  output logic         i_ack,
  output logic         i_rty,
  input  logic         d_stb,
  input  logic         d_we,
  input  logic [11:0]  d_adr,
  input  logic [127:0] d_dat_m,
  input  logic [15:0]  d_sel,
  output logic [127:0] d_dat_s,
  output logic         d_ack,
  output logic         d_rty,
  output logic         m_cyc,
  output logic         m_stb,
  output logic         m_we,
  output logic [11:0]  m_adr,
  output logic [127:0] m_dat_m,
  output logic [15:0]  m_sel,
  input  logic [127:0] m_dat_s,
  input  logic         m_ack,
  input  logic         m_rty
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;      // 0: I port, 1: D port
  logic           last_q, last_d;        // last port served, same encoding
  logic [7:0]     cnt_q, cnt_d;
  logic [127:0]   resp_q, resp_d;
  logic           res_ack_q, res_ack_d;  // 1: ACK result, 0: RTY result
  logic           we_q, we_d;
  logic [11:0]    adr_q, adr_d;
  logic [127:0]   dat_q, dat_d;
  logic [15:0]    sel_q, sel_d;
  logic           pick_d;
  logic           busy;
  logic           in_resp;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    res_ack_d = res_ack_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    // On a tie the port that was not served last wins.
    pick_d    = d_stb && (!i_stb || !last_q);
    unique case (state_q)
      StIdle: begin
        if (i_stb || d_stb) begin
          owner_d = pick_d;
          state_d = pick_d ? StBusyD : StBusyI;
          cnt_d   = 8'd0;
          we_d    = pick_d ? d_we    : i_we;
          adr_d   = pick_d ? d_adr   : i_adr;
          dat_d   = pick_d ? d_dat_m : i_dat_m;
          sel_d   = pick_d ? d_sel   : i_sel;
        end
      end
      StBusyI, StBusyD: begin
        cnt_d = cnt_q + 8'd1;
        if (m_ack) begin
          resp_d    = m_dat_s;
          res_ack_d = 1'b1;
          state_d   = StResp;
        end else if (m_rty || (cnt_d == 8'(TIMEOUT))) begin
          res_ack_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= 8'd0;
      resp_q    <= '0;
      res_ack_q <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      res_ack_q <= res_ack_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
    end
  end

  assign busy    = (state_q == StBusyI) || (state_q == StBusyD);
  assign in_resp = (state_q == StResp);

  assign m_cyc   = busy;
  assign m_stb   = busy;
  assign m_we    = we_q;
  assign m_adr   = adr_q;
  assign m_dat_m = dat_q;
  assign m_sel   = sel_q;

  // A requester that has already dropped its strobe never sees the result.
  assign i_ack   = in_resp && !owner_q &&  res_ack_q && i_stb;
  assign i_rty   = in_resp && !owner_q && !res_ack_q && i_stb;
  assign d_ack   = in_resp &&  owner_q &&  res_ack_q && d_stb;
  assign d_rty   = in_resp &&  owner_q && !res_ack_q && d_stb;
  assign i_dat_s = resp_q;
  assign d_dat_s = resp_q;

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum memory-side cycles per transaction before forced retry (range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_stb / d_stb  input  1  instruction / data port request (CYC==STB on CPU side).
REQ-005 i_we / d_we  input  1  port write enable.
REQ-006 i_adr / d_adr  input  12  port line address (byte address [15:4]).
REQ-007 i_dat_m / d_dat_m  input  128  port write line.
REQ-008 i_sel / d_sel  input  16  port byte enables.
REQ-009 i_dat_s / d_dat_s  output  128  read line returned to port.
REQ-010 i_ack / d_ack  output  1  port transfer complete, one-cycle pulse.
REQ-011 i_rty / d_rty  output  1  port transfer aborted, one-cycle pulse.
REQ-012 m_cyc / m_stb  output  1  memory bus cycle/strobe, always equal.
REQ-013 m_we  output  1  memory write enable.
REQ-014 m_adr  output  12  memory line address.
REQ-015 m_dat_m  output  128  memory write line.
REQ-016 m_sel  output  16  memory byte enables.
REQ-017 m_dat_s  input  128  memory read line.
REQ-018 m_ack / m_rty  input  1  memory acknowledge / retry.

Function
REQ-019 Shall implement states IDLE, BUSY_I, BUSY_D, RESP; last_grant register (I or D); 8-bit watchdog counter; 128-bit response register; latched request registers (we, adr, dat_m, sel).
REQ-020 IDLE, only one stb high at edge: grant that port, latch its we/adr/dat_m/sel, clear counter, go BUSY_x.
REQ-021 IDLE, both stb high: grant the port not equal to last_grant (round-robin).
REQ-022 BUSY_x: m_cyc=m_stb=1, m_we/m_adr/m_dat_m/m_sel driven only from latched registers; port input changes after grant ignored.
REQ-023 BUSY_x, m_ack sampled: capture m_dat_s into response register, go RESP with result ACK.
REQ-024 BUSY_x, m_rty sampled without m_ack: go RESP with result RTY.
REQ-025 m_ack and m_rty together: ACK wins; m_ack on the edge the counter reaches TIMEOUT: ACK wins.
REQ-026 Counter increments each BUSY cycle; reaching TIMEOUT with no ack/rty: go RESP with result RTY.
REQ-027 RESP (exactly one cycle): m_stb=0; owner's ack (or rty) =1 only if owner's stb still high, else response silently dropped; set last_grant=owner; next state IDLE.
REQ-028 Non-owner ack/rty always 0; ack and rty never both high.
REQ-029 i_dat_s and d_dat_s both driven from response register (valid when ack high; hold otherwise).
REQ-030 m_ack/m_rty outside BUSY ignored.
REQ-031 Latency: stb sampled edge N -> m_stb high cycle N+1; m_ack sampled edge M -> port ack high cycle M+1; minimum request-to-ack 2 cycles; one IDLE cycle between transactions.
REQ-032 No combinational path from port inputs to m_* outputs or from m_* inputs to port outputs.

Reset
REQ-033 rst_n low: immediately state IDLE, last_grant=I, counter=0, all registers 0, all outputs 0 (m_cyc, m_stb, acks, rtys, data, adr, sel).
REQ-034 rst_n low mid-transaction abandons it with no port ack/rty; first request after release serviced normally.

Verification
REQ-035 I read: i_stb=1, i_we=0, i_adr=0x012; memory acks 2 cycles later with m_dat_s=0x...DEAD -> m_adr=0x012 cycle 1, i_ack one cycle with i_dat_s=0x...DEAD, d_ack=0.
REQ-036 i_stb and d_stb rise together after reset, d_adr=0x020, i_adr=0x010 -> D served first (m_adr=0x020), then I (m_adr=0x010); repeated ties alternate.
REQ-037 D write d_sel=0x0030, d_dat_m changed after grant -> m_we=1, m_sel=0x0030, m_dat_m equals value at grant edge.
REQ-038 TIMEOUT=4, memory silent -> m_stb high 4 cycles then low, d_rty single pulse, d_ack=0; m_ack+m_rty same edge -> ack only.
REQ-039 rst_n pulsed low during BUSY_I -> m_stb 0 immediately, no i_ack; next d_stb request completes with d_ack.
